// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the vector-memory read arbiter.
//
// Contents:
//   NUM_REQ     - number of burst requesters sharing the memory port (2)
//   req_id_t    - requester identifier (1 bit)
//   arb_state_t - sequencer states: idle, issuing reads, final response
//   id_onehot() - one-hot request/grant vector for a requester id
package vmem_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StLast  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way requester select with a registered round-robin pointer.
//
// The pointer names the preferred requester when both request; after a grant
// to requester i the pointer moves to the other requester. A lone requester
// always wins regardless of the pointer.
//
// Build option:
//   VMEM_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie and
//                            the pointer register is not built.
//
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset (pointer to 0)
//   req_i     - per-requester request bits
//   gnt_en_i  - a grant is being taken this cycle; advance the pointer
//   valid_o   - at least one request is present
//   win_o     - selected requester (meaningful only when valid_o is high)
module rr_arb2
  import vmem_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_en_i,
  output logic               valid_o,
  output req_id_t            win_o
);

  logic tie_pick;

`ifdef VMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: no state is kept, so the clock, reset and grant enable
  // have no function here.
  logic unused_fixed_prio;
  assign unused_fixed_prio = ^{clk_i, rst_i, gnt_en_i};
  assign tie_pick          = 1'b0;
`else
  req_id_t ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (gnt_en_i) begin
      ptr_q <= ~win_o;
    end
  end

  assign tie_pick = ptr_q;
`endif

  assign valid_o = |req_i;

  always_comb begin
    win_o = 1'b0;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = tie_pick;
      default: win_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/vmem_read_arbiter.sv
// Burst read arbiter for the shared synchronous-read data-memory port.
//
// Two load requesters each present a level request with a base address and a
// word count. In IDLE the winner is chosen (round-robin, or fixed priority
// with VMEM_ARB_FIXED_PRIO_EN defined), its burst is latched and the
// sequencer issues consecutive (wrapping) addresses, one per cycle. Each word
// comes back one cycle after its read strobe, tagged with owner id and index.
// A LAST cycle carries the final response and the done pulse, and the
// following IDLE cycle acts as a bubble before the next grant.
//
// Build option:
//   VMEM_ARB_FIXED_PRIO_EN - fixed priority (requester 0 wins ties), handled
//                            inside rr_arb2.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - synchronous active-high reset; aborts any burst
//   req_i       - per-requester request, held until granted
//   req_base_i  - per-requester burst base address
//   req_len_i   - per-requester burst length in words (clamped to VLEN)
//   gnt_o       - one-hot, one-cycle grant pulse
//   mem_rd_en_o - memory read strobe
//   mem_addr_o  - memory read address
//   mem_rdata_i - memory read data, valid the cycle after mem_rd_en_o
//   rsp_valid_o - response word valid
//   rsp_id_o    - owner of the current burst
//   rsp_idx_o   - word index within the burst
//   rsp_data_o  - response word (memory data, zero when not valid)
//   done_o      - one-hot pulse on the owner's bit with the final response
//   busy_o      - sequencer not idle
module vmem_read_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int unsigned VLEN   = 20,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN_W  = $clog2(VLEN + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_base_i,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic                           mem_rd_en_o,
  output logic [ADDR_W-1:0]              mem_addr_o,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  output logic                           rsp_valid_o,
  output req_id_t                        rsp_id_o,
  output logic [LEN_W-1:0]               rsp_idx_o,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           busy_o
);

  // Burst context
  arb_state_t        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  req_id_t           id_q;
  logic [LEN_W-1:0]  cnt_q;     // index of the word issued this cycle

  // Registered outputs
  logic [NUM_REQ-1:0] gnt_q;
  logic               mem_rd_en_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               rsp_valid_q;
  req_id_t            rsp_id_q;
  logic [LEN_W-1:0]   rsp_idx_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;

  logic             arb_valid;
  req_id_t          arb_win;
  logic             gnt_take;
  logic [LEN_W-1:0] win_len;
  logic [LEN_W-1:0] cnt_nxt;
  logic             last_issue;

  // Requests are only looked at while idle; anything asserted during a burst
  // and dropped before the next idle cycle is never seen.
  assign gnt_take = (state_q == StIdle) && arb_valid;

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_en_i (gnt_take),
    .valid_o  (arb_valid),
    .win_o    (arb_win)
  );

  // Winner's length, clamped to the maximum burst
  always_comb begin
    win_len = req_len_i[arb_win];
    if (win_len > LEN_W'(VLEN)) begin
      win_len = LEN_W'(VLEN);
    end
  end

  assign cnt_nxt    = cnt_q + LEN_W'(1);
  assign last_issue = (cnt_q == (len_q - LEN_W'(1)));

  // Outputs are computed at each edge for the cycle that follows, so the
  // grant and first read strobe appear in the first ISSUE cycle and each
  // response lands together with the memory data for the previous strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_idx_q   <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Pulsed outputs default low
      gnt_q       <= '0;
      done_q      <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;

      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            base_q   <= req_base_i[arb_win];
            len_q    <= win_len;
            id_q     <= arb_win;
            cnt_q    <= '0;
            gnt_q    <= id_onehot(arb_win);
            rsp_id_q <= arb_win;
            busy_q   <= 1'b1;
            if (win_len == '0) begin
              // Empty burst: grant only, no read is issued
              state_q <= StLast;
            end else begin
              state_q     <= StIssue;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= req_base_i[arb_win];
            end
          end else begin
            busy_q <= 1'b0;
          end
        end

        StIssue: begin
          // Response for the word being read this cycle
          rsp_valid_q <= 1'b1;
          rsp_idx_q   <= cnt_q;
          if (last_issue) begin
            state_q <= StLast;
            done_q  <= id_onehot(id_q);
          end else begin
            cnt_q       <= cnt_nxt;
            mem_rd_en_q <= 1'b1;
            // Address arithmetic wraps at the top of the address space
            mem_addr_q  <= base_q + ADDR_W'(cnt_nxt);
          end
        end

        StLast: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          // An empty burst had no final word to carry done, so it is
          // signalled in the cycle after the grant instead.
          if (len_q == '0) begin
            done_q <= id_onehot(id_q);
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign mem_rd_en_o = mem_rd_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_idx_o   = rsp_idx_q;
  // Memory data passes straight through, held at zero outside a response
  assign rsp_data_o  = rsp_valid_q ? mem_rdata_i : '0;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_vmem_read_arbiter.sv
// Directed self-checking bench for vmem_read_arbiter.
// Memory model: synchronous read returning 866 + addr (so address 34 -> 900).
module tb_vmem_read_arbiter;

  logic            clk;
  logic            rst;
  logic [1:0]      req;
  logic [1:0][5:0] req_base;
  logic [1:0][4:0] req_len;
  logic [1:0]      gnt;
  logic            mem_rd_en;
  logic [5:0]      mem_addr;
  logic [9:0]      mem_rdata;
  logic            rsp_valid;
  logic            rsp_id;
  logic [4:0]      rsp_idx;
  logic [9:0]      rsp_data;
  logic [1:0]      done;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef VMEM_ARB_FIXED_PRIO_EN
  localparam logic RepeatFirst = 1'b0;
`else
  localparam logic RepeatFirst = 1'b1;
`endif

  vmem_read_arbiter #(
    .VLEN   (20),
    .DATA_W (10),
    .ADDR_W (6),
    .LEN_W  (5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .req_base_i  (req_base),
    .req_len_i   (req_len),
    .gnt_o       (gnt),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_idx_o   (rsp_idx),
    .rsp_data_o  (rsp_data),
    .done_o      (done),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 10'(866 + int'(mem_addr));
  end

  // {gnt, rd_en, addr, rsp_valid, rsp_id, rsp_idx, rsp_data, done, busy}
  function automatic logic [28:0] cur();
    return {gnt, mem_rd_en, mem_addr, rsp_valid, rsp_id, rsp_idx, rsp_data, done, busy};
  endfunction

  function automatic string fmt(input logic [28:0] p);
    return $sformatf("gnt=%b rd=%b addr=%0d v=%b id=%b idx=%0d data=%0d done=%b busy=%b",
                     p[28:27], p[26], p[25:20], p[19], p[18], p[17:13], p[12:3], p[2:1], p[0]);
  endfunction

  // Expected outputs k cycles after the edge that sampled the request.
  function automatic logic [28:0] exp_vec(input logic id, input int base, input int leff,
                                          input int k);
    logic [1:0] oh;
    logic [1:0] g;
    logic       rd;
    logic [5:0] a;
    logic       v;
    logic [4:0] idx;
    logic [9:0] d;
    logic [1:0] dn;
    logic       b;
    int         done_k;
    oh     = id ? 2'b10 : 2'b01;
    done_k = (leff == 0) ? 2 : leff + 1;
    g      = (k == 1) ? oh : 2'b00;
    rd     = (k >= 1) && (k <= leff);
    a      = rd ? 6'((base + k - 1) % 64) : 6'd0;
    v      = (k >= 2) && (k <= leff + 1);
    idx    = v ? 5'(k - 2) : 5'd0;
    d      = v ? 10'(866 + ((base + k - 2) % 64)) : 10'd0;
    dn     = (k == done_k) ? oh : 2'b00;
    b      = (k <= leff + 1);
    return {g, rd, a, v, id, idx, d, dn, b};
  endfunction

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  // Drive a request in the current (idle) cycle and step to the grant cycle.
  task automatic launch(input logic [1:0] r, input int b0, input int l0, input int b1,
                        input int l1);
    req         = r;
    req_base[0] = 6'(b0);
    req_len[0]  = 5'(l0);
    req_base[1] = 6'(b1);
    req_len[1]  = 5'(l1);
    @(posedge clk); #1;
  endtask

  // Called in the grant cycle; checks through the bubble cycle.
  task automatic burst_expect(input string name, input logic id, input int base, input int leff);
    for (int k = 1; k <= leff + 2; k++) begin
      check($sformatf("%s_k%0d", name, k), cur(), exp_vec(id, base, leff, k));
      if (k == 1) req[id] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [1:0] r;
    int         b0;
    int         l0;
    int         b1;
    int         l1;
    logic       id;
    int         eb;
    int         elen;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b01, 34, 4, 0, 0, 1'b0, 34, 4};    // basic burst
    vecs[1] = '{2'b01, 62, 4, 0, 0, 1'b0, 62, 4};    // address wrap
    vecs[2] = '{2'b10, 0, 0, 5, 0, 1'b1, 5, 0};      // empty burst
    vecs[3] = '{2'b01, 40, 25, 0, 0, 1'b0, 40, 20};  // clamp to VLEN
    vecs[4] = '{2'b10, 0, 0, 3, 1, 1'b1, 3, 1};      // single word
    vecs[5] = '{2'b10, 0, 0, 50, 20, 1'b1, 50, 20};  // full length with wrap

    rst      = 1'b1;
    req      = '0;
    req_base = '0;
    req_len  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", cur(), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", cur(), '0);

    // Contention from reset: pointer 0 wins, other requester after the bubble
    launch(2'b11, 10, 2, 20, 2);
    burst_expect("contA_first", 1'b0, 10, 2);
    burst_expect("contA_second", 1'b1, 20, 2);

    // Lone requester 0 leaves the pointer on requester 1
    launch(2'b01, 30, 1, 0, 0);
    burst_expect("pre_contB", 1'b0, 30, 1);

    launch(2'b11, 10, 2, 20, 2);
    burst_expect("contB_first", RepeatFirst, RepeatFirst ? 20 : 10, 2);
    burst_expect("contB_second", ~RepeatFirst, RepeatFirst ? 10 : 20, 2);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].r, vecs[i].b0, vecs[i].l0, vecs[i].b1, vecs[i].l1);
      burst_expect($sformatf("vec%0d", i), vecs[i].id, vecs[i].eb, vecs[i].elen);
    end

    // Reset during the third issue cycle aborts the burst
    launch(2'b01, 8, 6, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("rstmid_k%0d", k), cur(), exp_vec(1'b0, 8, 6, k));
      if (k == 1) req[0] = 1'b0;
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_outputs_zero", cur(), '0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_quiet%0d", k), cur(), '0);
    end

    // Pointer was 1 before reset; after reset requester 0 must win a tie
    launch(2'b11, 12, 1, 22, 1);
    burst_expect("post_rst_first", 1'b0, 12, 1);
    burst_expect("post_rst_second", 1'b1, 22, 1);
    launch(2'b10, 0, 0, 60, 3);
    burst_expect("post_rst_req1", 1'b1, 60, 3);

    // Requester 1 pulses mid-burst and drops; base 0 changes mid-burst
    launch(2'b01, 16, 5, 40, 3);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("withdraw_k%0d", k), cur(), exp_vec(1'b0, 16, 5, k));
      if (k == 1) req[0] = 1'b0;
      if (k == 2) begin
        req[1]      = 1'b1;
        req_base[0] = 6'd50;
      end
      if (k == 3) req[1] = 1'b0;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
